spi_regfile_peripheral: RTL

SPI_REGFILE_PERIPHERAL -- requirements
Module: spi_regfile_peripheral

---
 rtl/spi_regfile_peripheral.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS registers through {R/W, address, data} frames.
// Define SPI_READBACK_EN to build the read path (CIPO shift register and read frame errors).
module spi_regfile_peripheral #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  HDR_CNT    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  FRAME_CNT  = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, END} state_t;

  logic [1:0]         sclk_sync, copi_sync, ncs_sync;
  logic               sclk_prev, ncs_prev;
  logic               sclk_rise, ncs_rise, ncs_fall;
  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               overflow;
  logic               rw;
  logic [FRAME_W-1:0] rx, rx_next;
  logic               frame_ok;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  // NOTE: every clocked block uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      copi_sync <= {copi_sync[0], COPI};
      ncs_sync  <= {ncs_sync[0], nCS};
      sclk_prev <= sclk_sync[1];
      ncs_prev  <= ncs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign ncs_rise  = ncs_sync[1] & ~ncs_prev;
  assign ncs_fall  = ~ncs_sync[1] & ncs_prev;
  assign rx_next   = {rx[FRAME_W-2:0], copi_sync[1]};

  // A complete, non-overflowed frame whose address field hits a real register.
  assign frame_ok = (state == END) && !overflow && ({1'b0, rx[DATA_W +: ADDR_W]} < ADDR_LIMIT);

`ifdef SPI_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] rd_shift;

  assign sclk_fall = ~sclk_sync[1] & sclk_prev;

  function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = regs[i];
    return v;
  endfunction

  assign CIPO = (state == DATA) & ~rw & ~ncs_sync[1] & rd_shift[DATA_W-1];
`else
  assign CIPO = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      overflow  <= 1'b0;
      rw        <= 1'b0;
      rx        <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      // NOTE: the register file is small and must read back as zero after reset, so it is reset here.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef SPI_READBACK_EN
      rd_shift  <= '0;
`endif
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        // Deselect beats any same-cycle sclk edge; frames with no bits are dropped silently.
        state <= IDLE;
        if (state != IDLE && (state != ADDR || bit_cnt != '0)) begin
          if (rw) begin
            if (frame_ok) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (rx[DATA_W +: ADDR_W] == ADDR_W'(i)) regs[i] <= rx[DATA_W-1:0];
              wr_addr   <= rx[DATA_W +: ADDR_W];
              wr_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
`ifdef SPI_READBACK_EN
          else if (!frame_ok) begin
            frame_err <= 1'b1;
          end
`endif
        end
      end else begin
        unique case (state)
          IDLE: if (ncs_fall) begin
            state    <= ADDR;
            bit_cnt  <= '0;
            overflow <= 1'b0;
          end
          ADDR: if (sclk_rise) begin
            rx      <= rx_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == '0) rw <= copi_sync[1];
            if (bit_cnt + 1'b1 == HDR_CNT) begin
              state <= DATA;
`ifdef SPI_READBACK_EN
              if (!rx_next[ADDR_W]) rd_shift <= reg_at(rx_next[ADDR_W-1:0]);
`endif
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx      <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt + 1'b1 == FRAME_CNT) state <= END;
            end
`ifdef SPI_READBACK_EN
            // The fall right after the last address bit must not shift: bit MSB is not yet sampled.
            else if (sclk_fall && bit_cnt != HDR_CNT) begin
              rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
            end
`endif
          end
          END: if (sclk_rise) overflow <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule
